bp_fpga_top: RTL and testbench
==============================

Name: bp_fpga_top

Overview:
- Bus Pirate FPGA top level.
- Exposes a 16-bit asynchronous microcontroller (MCU) parallel bus to a small register file, a command FIFO and a result FIFO.
- A sequencer executes queued commands that drive the 5 IO-buffer pins (74LVC buffers: direction, open-drain, data) and an 8-bit output latch.
- Raises two interrupt lines; SRAM ports are reserved and parked.

Parameters:
BP_PINS, 5, number of buffered IO pins (1..8)
FIFO_DEPTH, 8, entries in each of the command and result FIFOs (power of two)

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset
bufio  inout  BP_PINS  pin data to/from buffers
bufdir  out  BP_PINS  1 = buffer drives pin (output)
bufod  out  BP_PINS  1 = pin is open-drain
lat_oe  out  1  latch output enable, active low
lat  out  8  latch data
mc_oe  in  1  MCU read strobe, active low
mc_ce  in  1  MCU chip enable, active low
mc_we  in  1  MCU write strobe, active low
mc_add  in  6  MCU register address
mc_data  inout  16  MCU data bus
irq0  out  1  result-available interrupt, active high
irq1  out  1  command-FIFO-empty interrupt, active high
sram_clock  out  1  reserved, held 0
sram0_cs, sram1_cs  out  1  reserved, held 1
sram0_sio, sram1_sio  inout  4  reserved, held Z

Behaviour:
- Reset values: dir=0, od=0, pin_out=0, irq_mask=0, lat=0x00, lat_oe=1, both FIFOs empty, sequencer IDLE, irq0=irq1=0.
- MCU synchronisation: mc_we, mc_oe and mc_ce each pass through a 2-FF synchroniser.
- Write commit: one commit on the synchronised falling edge of mc_we while synchronised mc_ce=0. mc_add and mc_data are sampled in that same cycle. The MCU holds address/data stable ≥3 clocks before and during mc_we low.
- Read: mc_data is driven combinationally from the read mux while mc_ce=0, mc_oe=0 and mc_we=1; otherwise it is Z. Register 0x00 is popped once, on the synchronised rising edge of mc_oe with ce low.
- Register map:
  - 0x00 W: push to command FIFO; dropped if full. 0x00 R: head of result FIFO; 0x0000 if empty.
  - 0x01 R: status {11'b0, busy, res_full, res_empty, cmd_full, cmd_empty}.
  - 0x19 R/W: dir[BP_PINS-1:0].
  - 0x1A R/W: od[BP_PINS-1:0].
  - 0x1B R/W: irq_mask[1:0].
  - All other addresses read 0; writes to them are ignored.
- Pin drive, per pin i: bufdir[i]=dir[i]; bufod[i]=od[i].
  - dir[i]=0: bufio[i]=Z.
  - dir[i]=1, od[i]=0: bufio[i]=pin_out[i].
  - dir[i]=1, od[i]=1: bufio[i]=0 when pin_out[i]=0, Z when pin_out[i]=1.
- Pin sampling: bufio is sampled through a 2-FF synchroniser.
- Sequencer states: IDLE, EXEC, WAIT.
  - IDLE: command FIFO non-empty → pop; next cycle EXEC.
  - Command word: opcode=data[15:8], arg=data[7:0].
  - 0x00 OUT: pin_out<=arg[BP_PINS-1:0]; back to IDLE.
  - 0x01 DELAY: load counter with arg; WAIT until counter=0 (arg+1 cycles); then IDLE.
  - 0x02 LAT: lat<=arg, lat_oe<=0; back to IDLE.
  - 0x03 READ: push zero-extended synchronised bufio into result FIFO. Stall in EXEC while the result FIFO is full.
  - Any other opcode: NOP.
- busy=1 whenever state≠IDLE.
- Interrupts (registered): irq0 = irq_mask[0] & !res_empty; irq1 = irq_mask[1] & cmd_empty & !busy.
- Simultaneous MCU push and sequencer pop on a full or empty FIFO must both succeed correctly; count stays consistent.
- Pointers wrap modulo FIFO_DEPTH.
- Reset mid-command aborts the command immediately and clears both FIFOs.

Test Plan:
- Reset: assert reset low → bufdir=0, bufod=0, bufio=Z, lat_oe=1, lat=0, irq0=irq1=0, status reads 0x0005.
- Config: write 0x19=0x0003, 0x1A=0x0003 → bufdir=00011, bufod=00011; read back 0x0003 from each.
- Sequence (buffer model returns 1 on released pins): write 0x00 with 0x0055, 0x0020, 0x0002, 0x0303 → pin0 driven 0, pin1 released. Read 0x00 → 0x001E; result FIFO then empty (status bit2=1).
- LAT and DELAY: push 0x01FF then 0x02A5 → lat=0xA5 and lat_oe=0 no earlier than 256 clocks after the delay starts; busy=1 throughout.
- Overflow: push 9 READ commands with no MCU reads → exactly 8 results stored; sequencer stalls busy; one pop lets the 9th complete.
- Interrupts: irq_mask=3; with FIFOs empty → irq1=1. Push a READ → irq0=1 after completion; reading 0x00 → irq0=0.

Source files
------------

// File: rtl/bp_fpga_top.sv
// Bus Pirate FPGA top level: MCU parallel bus to a small register file,
// a command FIFO feeding a pin/latch sequencer, and a result FIFO.
module bp_fpga_top #(
  parameter int BP_PINS    = 5,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clock,
  input  logic               reset,
  inout  wire  [BP_PINS-1:0] bufio,
  output logic [BP_PINS-1:0] bufdir,
  output logic [BP_PINS-1:0] bufod,
  output logic               lat_oe,
  output logic [7:0]         lat,
  input  logic               mc_oe,
  input  logic               mc_ce,
  input  logic               mc_we,
  input  logic [5:0]         mc_add,
  inout  wire  [15:0]        mc_data,
  output logic               irq0,
  output logic               irq1,
  output logic               sram_clock,
  output logic               sram0_cs,
  output logic               sram1_cs,
  inout  wire  [3:0]         sram0_sio,
  inout  wire  [3:0]         sram1_sio
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [2:0] we_sync_q, oe_sync_q;
  logic [1:0] ce_sync_q;
  logic [BP_PINS-1:0] pin_sync0_q, pin_sync1_q;

  logic [15:0] cmd_mem_q [FIFO_DEPTH];
  logic [15:0] res_mem_q [FIFO_DEPTH];
  logic [AW-1:0] cmd_wr_ptr_q, cmd_wr_ptr_d, cmd_rd_ptr_q, cmd_rd_ptr_d;
  logic [AW-1:0] res_wr_ptr_q, res_wr_ptr_d, res_rd_ptr_q, res_rd_ptr_d;
  logic [AW:0]   cmd_cnt_q, cmd_cnt_d, res_cnt_q, res_cnt_d;

  logic [1:0]         state_q, state_d;
  logic [15:0]        cmd_word_q, cmd_word_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [BP_PINS-1:0] pin_out_q, pin_out_d;
  logic [BP_PINS-1:0] dir_q, dir_d, od_q, od_d;
  logic [1:0]         irq_mask_q, irq_mask_d;
  logic [7:0]         lat_q, lat_d;
  logic               lat_oe_q, lat_oe_d;
  logic               irq0_q, irq0_d, irq1_q, irq1_d;

  logic we_fall, oe_rise, cmd_push, seq_pop, seq_push, rd_pop;
  logic cmd_empty, cmd_full, res_empty, res_full, busy;
  logic [15:0] res_word, rd_data;

  assign cmd_empty = (cmd_cnt_q == '0);
  assign cmd_full  = (cmd_cnt_q == DEPTH);
  assign res_empty = (res_cnt_q == '0);
  assign res_full  = (res_cnt_q == DEPTH);
  assign busy      = (state_q != ST_IDLE);

  // Strobe edges are taken from the synchronised copies; ce must be low too.
  assign we_fall  = we_sync_q[2] & ~we_sync_q[1] & ~ce_sync_q[1];
  assign oe_rise  = ~oe_sync_q[2] & oe_sync_q[1] & ~ce_sync_q[1];
  assign seq_pop  = (state_q == ST_IDLE) & ~cmd_empty;
  assign rd_pop   = oe_rise & (mc_add == 6'h00) & ~res_empty;
  // A full FIFO still accepts a push in the same cycle as its pop.
  assign cmd_push = we_fall & (mc_add == 6'h00) & (~cmd_full | seq_pop);
  assign seq_push = (state_q == ST_EXEC) & (cmd_word_q[15:8] == 8'h03) & (~res_full | rd_pop);
  assign res_word = {{(16-BP_PINS){1'b0}}, pin_sync1_q};

  // Two-flop synchronisers for the MCU strobes and the sampled pins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      we_sync_q   <= '1;
      oe_sync_q   <= '1;
      ce_sync_q   <= '1;
      pin_sync0_q <= '0;
      pin_sync1_q <= '0;
    end else begin
      we_sync_q   <= {we_sync_q[1:0], mc_we};
      oe_sync_q   <= {oe_sync_q[1:0], mc_oe};
      ce_sync_q   <= {ce_sync_q[0], mc_ce};
      pin_sync0_q <= bufio;
      pin_sync1_q <= pin_sync0_q;
    end
  end

  // FIFO storage; contents need no reset because the counts gate every read.
  always_ff @(posedge clock) begin
    if (cmd_push) cmd_mem_q[cmd_wr_ptr_q] <= mc_data;
    if (seq_push) res_mem_q[res_wr_ptr_q] <= res_word;
  end

  // FIFO pointers/counts, register writes, sequencer and interrupt next-state.
  always_comb begin
    cmd_wr_ptr_d = cmd_wr_ptr_q + (cmd_push ? AW'(1) : AW'(0));
    cmd_rd_ptr_d = cmd_rd_ptr_q + (seq_pop  ? AW'(1) : AW'(0));
    res_wr_ptr_d = res_wr_ptr_q + (seq_push ? AW'(1) : AW'(0));
    res_rd_ptr_d = res_rd_ptr_q + (rd_pop   ? AW'(1) : AW'(0));
    cmd_cnt_d    = cmd_cnt_q + (cmd_push ? (AW+1)'(1) : '0) - (seq_pop ? (AW+1)'(1) : '0);
    res_cnt_d    = res_cnt_q + (seq_push ? (AW+1)'(1) : '0) - (rd_pop  ? (AW+1)'(1) : '0);

    dir_d      = dir_q;
    od_d       = od_q;
    irq_mask_d = irq_mask_q;
    if (we_fall) begin
      case (mc_add)
        6'h19:   dir_d      = mc_data[BP_PINS-1:0];
        6'h1A:   od_d       = mc_data[BP_PINS-1:0];
        6'h1B:   irq_mask_d = mc_data[1:0];
        default: ;
      endcase
    end

    state_d    = state_q;
    cmd_word_d = cmd_word_q;
    cnt_d      = cnt_q;
    pin_out_d  = pin_out_q;
    lat_d      = lat_q;
    lat_oe_d   = lat_oe_q;
    case (state_q)
      ST_IDLE: begin
        if (!cmd_empty) begin
          cmd_word_d = cmd_mem_q[cmd_rd_ptr_q];
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (cmd_word_q[15:8])
          8'h00: begin
            pin_out_d = cmd_word_q[BP_PINS-1:0];
            state_d   = ST_IDLE;
          end
          8'h01: begin
            cnt_d   = cmd_word_q[7:0];
            state_d = ST_WAIT;
          end
          8'h02: begin
            lat_d    = cmd_word_q[7:0];
            lat_oe_d = 1'b0;
            state_d  = ST_IDLE;
          end
          8'h03: begin
            if (seq_push) state_d = ST_IDLE;
          end
          default: state_d = ST_IDLE;
        endcase
      end
      ST_WAIT: begin
        if (cnt_q == 8'd0) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = ST_IDLE;
    endcase

    irq0_d = irq_mask_q[0] & ~res_empty;
    irq1_d = irq_mask_q[1] & cmd_empty & ~busy;
  end

  // Control and configuration state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cmd_wr_ptr_q <= '0;
      cmd_rd_ptr_q <= '0;
      res_wr_ptr_q <= '0;
      res_rd_ptr_q <= '0;
      cmd_cnt_q    <= '0;
      res_cnt_q    <= '0;
      state_q      <= ST_IDLE;
      cmd_word_q   <= '0;
      cnt_q        <= '0;
      pin_out_q    <= '0;
      dir_q        <= '0;
      od_q         <= '0;
      irq_mask_q   <= '0;
      lat_q        <= '0;
      lat_oe_q     <= 1'b1;
      irq0_q       <= 1'b0;
      irq1_q       <= 1'b0;
    end else begin
      cmd_wr_ptr_q <= cmd_wr_ptr_d;
      cmd_rd_ptr_q <= cmd_rd_ptr_d;
      res_wr_ptr_q <= res_wr_ptr_d;
      res_rd_ptr_q <= res_rd_ptr_d;
      cmd_cnt_q    <= cmd_cnt_d;
      res_cnt_q    <= res_cnt_d;
      state_q      <= state_d;
      cmd_word_q   <= cmd_word_d;
      cnt_q        <= cnt_d;
      pin_out_q    <= pin_out_d;
      dir_q        <= dir_d;
      od_q         <= od_d;
      irq_mask_q   <= irq_mask_d;
      lat_q        <= lat_d;
      lat_oe_q     <= lat_oe_d;
      irq0_q       <= irq0_d;
      irq1_q       <= irq1_d;
    end
  end

  // MCU read mux; addresses outside the map read as zero.
  always_comb begin
    rd_data = 16'h0000;
    case (mc_add)
      6'h00:   rd_data = res_empty ? 16'h0000 : res_mem_q[res_rd_ptr_q];
      6'h01:   rd_data = {11'b0, busy, res_full, res_empty, cmd_full, cmd_empty};
      6'h19:   rd_data = {{(16-BP_PINS){1'b0}}, dir_q};
      6'h1A:   rd_data = {{(16-BP_PINS){1'b0}}, od_q};
      6'h1B:   rd_data = {14'b0, irq_mask_q};
      default: ;
    endcase
  end

  assign mc_data = (!mc_ce && !mc_oe && mc_we) ? rd_data : 16'bz;

  // Open-drain pins only ever pull low; a released pin is left to the buffer.
  for (genvar i = 0; i < BP_PINS; i++) begin : g_pin
    assign bufio[i] = (dir_q[i] && !(od_q[i] && pin_out_q[i])) ? pin_out_q[i] : 1'bz;
  end

  assign bufdir     = dir_q;
  assign bufod      = od_q;
  assign lat        = lat_q;
  assign lat_oe     = lat_oe_q;
  assign irq0       = irq0_q;
  assign irq1       = irq1_q;
  assign sram_clock = 1'b0;
  assign sram0_cs   = 1'b1;
  assign sram1_cs   = 1'b1;
  assign sram0_sio  = 4'bz;
  assign sram1_sio  = 4'bz;
endmodule

// File: tb/tb_bp_fpga_top.sv
// Bench for bp_fpga_top: MCU bus tasks, a reference model of the command
// language, and a scoreboard fed by result-register reads.
module tb_bp_fpga_top;
  localparam int NP = 5;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic mc_oe = 1'b1, mc_ce = 1'b1, mc_we = 1'b1;
  logic [5:0]  mc_add = '0;
  logic [15:0] drv_data = '0;
  logic        drv_en = 1'b0;
  wire  [15:0] mc_data;
  wire  [NP-1:0] bufio;
  wire  [3:0] sram0_sio, sram1_sio;
  logic [NP-1:0] bufdir, bufod;
  logic lat_oe, irq0, irq1, sram_clock, sram0_cs, sram1_cs;
  logic [7:0] lat;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  logic [NP-1:0] m_dir = '0, m_od = '0, m_pout = '0;

  assign mc_data = drv_en ? drv_data : 16'bz;

  // Buffer model: released pins read back high.
  for (genvar i = 0; i < NP; i++) begin : g_pu
    pullup (bufio[i]);
  end

  bp_fpga_top #(.BP_PINS(NP), .FIFO_DEPTH(8)) dut (
    .clock(clock), .reset(reset), .bufio(bufio), .bufdir(bufdir), .bufod(bufod),
    .lat_oe(lat_oe), .lat(lat), .mc_oe(mc_oe), .mc_ce(mc_ce), .mc_we(mc_we),
    .mc_add(mc_add), .mc_data(mc_data), .irq0(irq0), .irq1(irq1),
    .sram_clock(sram_clock), .sram0_cs(sram0_cs), .sram1_cs(sram1_cs),
    .sram0_sio(sram0_sio), .sram1_sio(sram1_sio));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  // Level seen on each pin given the driver settings and a pull-up buffer.
  function automatic logic [15:0] pin_model(input logic [NP-1:0] d, input logic [NP-1:0] o,
                                            input logic [NP-1:0] p);
    logic [15:0] r = '0;
    for (int i = 0; i < NP; i++) begin
      if (d[i] && !o[i])      r[i] = p[i];
      else if (d[i] && !p[i]) r[i] = 1'b0;
      else                    r[i] = 1'b1;
    end
    return r;
  endfunction

  task automatic mcu_write(input logic [5:0] a, input logic [15:0] d);
    @(posedge clock); #1;
    mc_add = a; drv_data = d; drv_en = 1'b1; mc_ce = 1'b0;
    repeat (3) @(posedge clock); #1 mc_we = 1'b0;
    repeat (4) @(posedge clock); #1 mc_we = 1'b1;
    repeat (4) @(posedge clock); #1 mc_ce = 1'b1; drv_en = 1'b0;
  endtask

  task automatic mcu_read(input logic [5:0] a, output logic [15:0] d);
    @(posedge clock); #1;
    mc_add = a; mc_ce = 1'b0; mc_oe = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock) d = mc_data;
    @(posedge clock); #1 mc_oe = 1'b1;
    repeat (4) @(posedge clock); #1 mc_ce = 1'b1;
  endtask

  task automatic write_reg(input logic [5:0] a, input logic [15:0] d);
    mcu_write(a, d);
    if (a == 6'h19) m_dir = d[NP-1:0];
    if (a == 6'h1A) m_od  = d[NP-1:0];
  endtask

  // Command push; the model applies each command in queue order.
  task automatic push_cmd(input logic [15:0] w);
    mcu_write(6'h00, w);
    if (w[15:8] == 8'h00) m_pout = w[NP-1:0];
    if (w[15:8] == 8'h03) exp_q.push_back(pin_model(m_dir, m_od, m_pout));
  endtask

  task automatic read_res();
    logic [15:0] d;
    mcu_read(6'h00, d);
    obs_q.push_back(d);
  endtask

  task automatic check_reg(input string name, input logic [5:0] a, input logic [15:0] want);
    logic [15:0] d;
    mcu_read(a, d);
    chk(name, 32'(d), 32'(want));
  endtask

  task automatic wait_idle();
    logic [15:0] s;
    bit ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      mcu_read(6'h01, s);
      if (!s[4] && s[0]) ok = 1'b1;
    end
    if (!ok) chk("idle_timeout", 32'(s), 32'h5);
  endtask

  // Scoreboard monitor: each result-register read is matched to the model.
  initial begin
    logic [15:0] o, e;
    forever begin
      @(negedge clock);
      if (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'h0000;
        chk("res_fifo", 32'(o), 32'(e));
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: got cycle %0d want finish", cyc);
    $fatal(1);
  end

  initial begin
    int n, t0, t1;
    bit seen;
    logic [NP-1:0] rd, ro;
    logic [15:0] w;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_bufdir", 32'(bufdir), 32'h0);
    chk("rst_bufod", 32'(bufod), 32'h0);
    chk("rst_bufio", 32'(bufio), 32'h1F);
    chk("rst_lat_oe", 32'(lat_oe), 32'h1);
    chk("rst_lat", 32'(lat), 32'h0);
    chk("rst_irq", 32'({irq1, irq0}), 32'h0);
    chk("rst_sram", 32'({sram_clock, sram0_cs, sram1_cs}), 32'h3);
    @(posedge clock); #1 reset = 1'b1;
    check_reg("rst_status", 6'h01, 16'h0005);

    // Configuration
    write_reg(6'h19, 16'h0003);
    write_reg(6'h1A, 16'h0003);
    @(negedge clock);
    chk("cfg_bufdir", 32'(bufdir), 32'h03);
    chk("cfg_bufod", 32'(bufod), 32'h03);
    check_reg("cfg_dir_rb", 6'h19, 16'h0003);
    check_reg("cfg_od_rb", 6'h1A, 16'h0003);
    check_reg("unmapped_rd", 6'h2A, 16'h0000);

    // Command sequence with a READ
    push_cmd(16'h0055);
    push_cmd(16'h0020);
    push_cmd(16'h0002);
    push_cmd(16'h0303);
    wait_idle();
    @(negedge clock);
    chk("seq_pins", 32'(bufio[1:0]), 32'h2);
    read_res();
    repeat (2) @(negedge clock);
    check_reg("seq_status", 6'h01, 16'h0005);

    // DELAY then LAT
    t0 = cyc;
    push_cmd(16'h01FF);
    push_cmd(16'h02A5);
    check_reg("delay_busy", 6'h01, 16'h0014);
    @(negedge clock);
    chk("delay_lat_oe", 32'(lat_oe), 32'h1);
    seen = 1'b0;
    for (int k = 0; k < 1000 && !seen; k++) begin
      @(negedge clock);
      if (!lat_oe) seen = 1'b1;
    end
    t1 = cyc;
    chk("lat_seen", 32'(seen), 32'h1);
    chk("lat_val", 32'(lat), 32'hA5);
    chk("delay_len", 32'((t1 - t0) >= 256), 32'h1);
    wait_idle();

    // Result FIFO overflow stalls the sequencer
    for (int k = 0; k < 9; k++) push_cmd(16'h0303);
    repeat (20) @(posedge clock);
    check_reg("ovf_status", 6'h01, 16'h0019);
    read_res();
    repeat (10) @(posedge clock);
    check_reg("ovf_after_pop", 6'h01, 16'h0009);
    for (int k = 0; k < 8; k++) read_res();
    repeat (2) @(negedge clock);
    check_reg("ovf_drained", 6'h01, 16'h0005);

    // Interrupts
    write_reg(6'h1B, 16'h0003);
    repeat (3) @(negedge clock);
    chk("irq1_empty", 32'(irq1), 32'h1);
    chk("irq0_none", 32'(irq0), 32'h0);
    check_reg("mask_rb", 6'h1B, 16'h0003);
    push_cmd(16'h0303);
    wait_idle();
    repeat (2) @(negedge clock);
    chk("irq0_result", 32'(irq0), 32'h1);
    read_res();
    repeat (2) @(negedge clock);
    chk("irq0_cleared", 32'(irq0), 32'h0);

    // Randomised configurations and command streams
    for (int it = 0; it < 15; it++) begin
      rd = NP'($urandom_range(0, 31));
      ro = NP'($urandom_range(0, 31));
      write_reg(6'h19, 16'(rd));
      write_reg(6'h1A, 16'(ro));
      @(negedge clock);
      chk("rnd_bufdir", 32'(bufdir), 32'(rd));
      chk("rnd_bufod", 32'(bufod), 32'(ro));
      n = $urandom_range(1, 4);
      for (int j = 0; j < n; j++) begin
        case ($urandom_range(0, 3))
          0: w = {8'h00, 8'($urandom)};
          1: w = 16'h0303;
          2: w = {8'($urandom_range(4, 255)), 8'($urandom)};
          default: w = {8'h01, 8'($urandom_range(0, 15))};
        endcase
        push_cmd(w);
      end
      push_cmd({8'h03, 8'($urandom)});
      wait_idle();
      @(negedge clock);
      chk("rnd_pins", 32'(bufio), 32'(pin_model(m_dir, m_od, m_pout)));
      repeat (2) @(negedge clock);
      n = exp_q.size();
      for (int j = 0; j < n + 1; j++) read_res();
      repeat (2) @(negedge clock);
    end

    // Reset in the middle of a delay aborts everything
    push_cmd(16'h01FF);
    push_cmd(16'h0303);
    repeat (10) @(posedge clock);
    #1 reset = 1'b0;
    exp_q.delete();
    m_dir = '0; m_od = '0; m_pout = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_lat_oe", 32'(lat_oe), 32'h1);
    chk("mid_rst_bufdir", 32'(bufdir), 32'h0);
    check_reg("mid_rst_status", 6'h01, 16'h0005);
    read_res();

    repeat (5) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
